ssd_mux_counter: RTL

//  Parametrised N-digit multiplexed 7-segment counter/display driver. Holds a hex or BCD

---
 rtl/ssd_mux_counter.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/ssd_mux_counter.sv
// ssd_mux_counter: N-digit multiplexed 7-segment up/down counter and display driver.
// Holds a hex or BCD value that steps once per prescaled tick (or is loaded), and scans
// it digit by digit onto a shared segment bus with a one-hot digit select.
// Build option: define SSD_LZ_BLANK_EN to blank leading-zero digits above digit 0.
module ssd_mux_counter #(
    parameter int CLK_HZ     = 80_000_000,
    parameter int TICK_HZ    = 1,
    parameter int DIGITS     = 2,
    parameter int REFRESH_HZ = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  bcd_mode,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   value,
    output logic                  wrap,
    output logic [6:0]            segment,
    output logic [DIGITS-1:0]     digit_sel
);

    localparam int TICK_DIV = (TICK_HZ > 0) ? (CLK_HZ / TICK_HZ) : 0;
    localparam int SCAN_DIV = ((REFRESH_HZ > 0) && (DIGITS > 0)) ? (CLK_HZ / (REFRESH_HZ * DIGITS)) : 0;
    localparam int VW       = 4 * DIGITS;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(32'd1);
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_ONE = SCAN_W'(32'd1);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(32'd1);
    localparam logic [VW-1:0]     ZERO_V   = {VW{1'b0}};
    localparam logic [VW-1:0]     ALL_F_V  = {VW{1'b1}};
    localparam logic [VW-1:0]     ONE_V    = VW'(32'd1);

    // Parameter sanity: stop elaboration on an unbuildable configuration.
    generate
        if ((DIGITS < 1) || (DIGITS > 8)) begin : g_bad_digits
            $fatal(1, "ssd_mux_counter: DIGITS must be in 1..8");
        end
        if (TICK_DIV < 2) begin : g_bad_tick
            $fatal(1, "ssd_mux_counter: CLK_HZ/TICK_HZ must be at least 2");
        end
        if (SCAN_DIV < 1) begin : g_bad_scan
            $fatal(1, "ssd_mux_counter: CLK_HZ/(REFRESH_HZ*DIGITS) must be at least 1");
        end
    endgenerate

    // Saturate every nibble above 9 down to 9 so decimal arithmetic starts from a valid digit.
    function automatic logic [VW-1:0] bcd_clamp(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        end
        return r;
    endfunction

    // Decimal +/-1 with ripple carry/borrow; MSB of the result is the wrap-out.
    function automatic logic [VW:0] bcd_step(input logic [VW-1:0] v, input logic up_i);
        logic [VW-1:0] r;
        logic          c;
        logic [3:0]    nib;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            nib = v[4*i +: 4];
            if (!c) begin
                r[4*i +: 4] = nib;
            end else if (up_i) begin
                if (nib == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                    c           = 1'b1;
                end else begin
                    r[4*i +: 4] = nib + 4'd1;
                    c           = 1'b0;
                end
            end else begin
                if (nib == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                    c           = 1'b1;
                end else begin
                    r[4*i +: 4] = nib - 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    // Segment pattern {a,b,c,d,e,f,g} for one hex digit.
    function automatic logic [6:0] ssd_font(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h7E;
            4'h1:    s = 7'h30;
            4'h2:    s = 7'h6D;
            4'h3:    s = 7'h79;
            4'h4:    s = 7'h33;
            4'h5:    s = 7'h5B;
            4'h6:    s = 7'h5F;
            4'h7:    s = 7'h70;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h7B;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h1F;
            4'hC:    s = 7'h4E;
            4'hD:    s = 7'h3D;
            4'hE:    s = 7'h4F;
            4'hF:    s = 7'h47;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick_s;
    logic [VW-1:0]     value_q, value_d;
    logic              wrap_q, wrap_d;
    logic [VW-1:0]     clamped_s;
    logic [VW:0]       bcd_next_s;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic              scan_wrap_s;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [3:0]        nib_s;
    logic [DIGITS-1:0] blank_s;
    logic              blank_cur_s;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] sel_q, sel_d;

    // Tick prescaler: free-running 0..TICK_DIV-1, tick on the terminal count.
    always_comb begin
        tick_s     = (tick_cnt_q == TICK_MAX);
        tick_cnt_d = tick_s ? {TICK_W{1'b0}} : (tick_cnt_q + TICK_ONE);
    end

    // Next count value: load beats tick, tick steps in the currently selected radix.
    always_comb begin
        clamped_s  = bcd_clamp(value_q);
        bcd_next_s = bcd_step(clamped_s, up_dn);
        value_d    = value_q;
        wrap_d     = 1'b0;
        if (load) begin
            value_d = bcd_mode ? bcd_clamp(load_val) : load_val;
            wrap_d  = 1'b0;
        end else if (tick_s && en) begin
            if (bcd_mode) begin
                value_d = bcd_next_s[VW-1:0];
                wrap_d  = bcd_next_s[VW];
            end else if (up_dn) begin
                value_d = value_q + ONE_V;
                wrap_d  = (value_q == ALL_F_V);
            end else begin
                value_d = value_q - ONE_V;
                wrap_d  = (value_q == ZERO_V);
            end
        end else begin
            value_d = value_q;
            wrap_d  = 1'b0;
        end
    end

    // Scan timing: idx advances one digit each time the scan divider wraps.
    always_comb begin
        scan_wrap_s = (scan_cnt_q == SCAN_MAX);
        scan_cnt_d  = scan_wrap_s ? {SCAN_W{1'b0}} : (scan_cnt_q + SCAN_ONE);
        if (scan_wrap_s) begin
            idx_d = (idx_q == IDX_MAX) ? {IDX_W{1'b0}} : (idx_q + IDX_ONE);
        end else begin
            idx_d = idx_q;
        end
    end

    // Display data for the digit currently addressed by idx, including optional blanking.
    always_comb begin
        nib_s       = 4'd0;
        blank_cur_s = 1'b0;
        sel_d       = {DIGITS{1'b0}};
`ifdef SSD_LZ_BLANK_EN
        begin : blk_lz
            logic upper_zero;
            upper_zero = 1'b1;
            blank_s    = {DIGITS{1'b0}};
            for (int i = DIGITS - 1; i >= 0; i--) begin
                upper_zero = upper_zero & (value_q[4*i +: 4] == 4'd0);
                blank_s[i] = upper_zero & (i != 0);
            end
        end
`else
        blank_s = {DIGITS{1'b0}};
`endif
        for (int i = 0; i < DIGITS; i++) begin
            nib_s       = (idx_q == IDX_W'(i)) ? value_q[4*i +: 4] : nib_s;
            blank_cur_s = (idx_q == IDX_W'(i)) ? blank_s[i] : blank_cur_s;
            sel_d[i]    = (idx_q == IDX_W'(i));
        end
        seg_d = blank_cur_s ? 7'h00 : ssd_font(nib_s);
    end

    // Counter state: prescaler, value and wrap pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= {TICK_W{1'b0}};
            value_q    <= {VW{1'b0}};
            wrap_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            value_q    <= value_d;
            wrap_q     <= wrap_d;
        end
    end

    // Scan state and display outputs; segment and digit_sel share one edge so they never skew.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= {SCAN_W{1'b0}};
            idx_q      <= {IDX_W{1'b0}};
            seg_q      <= 7'h00;
            sel_q      <= {DIGITS{1'b0}};
        end else begin
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            sel_q      <= sel_d;
        end
    end

    assign value     = value_q;
    assign wrap      = wrap_q;
    assign segment   = seg_q;
    assign digit_sel = sel_q;

endmodule
